// File: rtl/serial_full_adder_seq_if.sv
// Operand/result handshake bundle for serial_full_adder_seq.
// Optional macro SERIAL_FULL_ADDER_SUB_EN adds the sub request bit.
interface serial_full_adder_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_FULL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

`ifdef SERIAL_FULL_ADDER_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/serial_full_adder_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder stage plus registered carry, LSB first.
// Optional macro SERIAL_FULL_ADDER_SUB_EN enables a - b via the sub request bit.
module serial_full_adder_seq #(
    parameter int unsigned WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    serial_full_adder_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_a_sr, w_a_sr_next;
    logic [WIDTH-1:0] r_b_sr, w_b_sr_next;
    logic [WIDTH-1:0] r_sum_sr, w_sum_sr_next;
    logic [WIDTH-1:0] r_sum, w_sum_next;
    logic             r_cout, w_cout_next;
    logic             r_carry, w_carry_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_sum_shift;

    // The single full-adder stage
    assign w_s = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_c = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));

    always_comb begin
        w_sum_shift            = r_sum_sr >> 1;
        w_sum_shift[WIDTH-1]   = w_s;
    end

    always_comb begin
        w_state_next  = r_state;
        w_a_sr_next   = r_a_sr;
        w_b_sr_next   = r_b_sr;
        w_sum_sr_next = r_sum_sr;
        w_sum_next    = r_sum;
        w_cout_next   = r_cout;
        w_carry_next  = r_carry;
        w_cnt_next    = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_a_sr_next   = bus.a;
                    w_sum_sr_next = '0;
                    w_cnt_next    = '0;
`ifdef SERIAL_FULL_ADDER_SUB_EN
                    // a - b == a + ~b + 1; cout then reads as "no borrow"
                    w_b_sr_next   = bus.sub ? ~bus.b : bus.b;
                    w_carry_next  = bus.sub ? 1'b1 : bus.cin;
`else
                    w_b_sr_next   = bus.b;
                    w_carry_next  = bus.cin;
`endif
                    w_state_next  = StRun;
                end
            end
            StRun: begin
                w_a_sr_next   = r_a_sr >> 1;
                w_b_sr_next   = r_b_sr >> 1;
                w_sum_sr_next = w_sum_shift;
                w_carry_next  = w_c;
                w_cnt_next    = r_cnt + CW'(1);
                if (r_cnt == LAST) begin
                    w_sum_next   = w_sum_shift;
                    w_cout_next  = w_c;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_a_sr   <= w_a_sr_next;
            r_b_sr   <= w_b_sr_next;
            r_sum_sr <= w_sum_sr_next;
            r_sum    <= w_sum_next;
            r_cout   <= w_cout_next;
            r_carry  <= w_carry_next;
            r_cnt    <= w_cnt_next;
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.busy      = (r_state != StIdle);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule
